// File: rtl/bp_be_fe_replay_queue.sv
// Replay queue between the FE queue and BE issue: entries stay resident from
// enqueue until commit so a rollback can re-issue them and a clear can drop them.
module bp_be_fe_replay_queue
  #(parameter int els_p        = 16
   ,parameter int data_width_p = 64
   )
  (input  logic                    clk_i
  ,input  logic                    reset_i

  ,input  logic                    clr_v_i
  ,input  logic                    deq_v_i
  ,input  logic                    roll_v_i

  ,input  logic [data_width_p-1:0] data_i
  ,input  logic                    v_i
  ,output logic                    ready_o

  ,output logic [data_width_p-1:0] data_o
  ,output logic                    v_o
  ,input  logic                    yumi_i

  ,output logic                    empty_o
  );

  localparam int idx_width_lp = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int ptr_width_lp = idx_width_lp + 1;

  typedef logic [ptr_width_lp-1:0] ptr_t;
  typedef logic [idx_width_lp-1:0] idx_t;

  ptr_t wptr_r, rptr_r, cptr_r;
  ptr_t wptr_n, rptr_n, cptr_n;
  logic [data_width_p-1:0] mem_r [els_p];

  idx_t wptr_idx, rptr_idx, cptr_idx;
  logic wptr_wrap, cptr_wrap;
  logic full, enq;

  assign wptr_idx  = wptr_r[idx_width_lp-1:0];
  assign rptr_idx  = rptr_r[idx_width_lp-1:0];
  assign cptr_idx  = cptr_r[idx_width_lp-1:0];
  assign wptr_wrap = wptr_r[ptr_width_lp-1];
  assign cptr_wrap = cptr_r[ptr_width_lp-1];

  // Same slot, opposite lap: the writer has caught up with the oldest uncommitted entry.
  assign full    = (wptr_idx == cptr_idx) & (wptr_wrap != cptr_wrap);
  assign ready_o = ~full;
  assign v_o     = (rptr_r != wptr_r);
  assign empty_o = (cptr_r == wptr_r);
  assign data_o  = mem_r[rptr_idx];

  assign enq = v_i & ~full;

  always_comb begin
    wptr_n = enq ? wptr_r + ptr_t'(1) : wptr_r;
    rptr_n = rptr_r;
    cptr_n = cptr_r;
    // Flush collapses onto the pre-enqueue write pointer so a same-cycle write survives.
    if (clr_v_i) begin
      rptr_n = wptr_r;
      cptr_n = wptr_r;
    end else if (roll_v_i) begin
      rptr_n = cptr_r;
    end else begin
      if (yumi_i)  rptr_n = rptr_r + ptr_t'(1);
      if (deq_v_i) cptr_n = cptr_r + ptr_t'(1);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wptr_r <= '0;
      rptr_r <= '0;
      cptr_r <= '0;
    end else begin
      wptr_r <= wptr_n;
      rptr_r <= rptr_n;
      cptr_r <= cptr_n;
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq) mem_r[wptr_idx] <= data_i;
  end

  a_yumi_needs_valid: assert property (@(posedge clk_i) disable iff (reset_i)
    yumi_i |-> v_o)
    else $error("replay queue: yumi_i with no unissued entry");

  a_deq_needs_issued: assert property (@(posedge clk_i) disable iff (reset_i)
    deq_v_i |-> (cptr_r != rptr_r))
    else $error("replay queue: deq_v_i with nothing issued");

endmodule

// File: tb/tb_bp_be_fe_replay_queue.sv
// Bench for bp_be_fe_replay_queue: fixed vector table plus a queue-based
// reference model of the uncommitted entries for the multi-cycle sequences.
module tb_bp_be_fe_replay_queue;

  localparam int ELS = 16;
  localparam int DW  = 64;

  logic          clk_i = 1'b0;
  logic          reset_i = 1'b1;
  logic          clr_v_i = 1'b0, deq_v_i = 1'b0, roll_v_i = 1'b0;
  logic [DW-1:0] data_i = '0;
  logic          v_i = 1'b0, yumi_i = 1'b0;
  logic          ready_o, v_o, empty_o;
  logic [DW-1:0] data_o;

  bp_be_fe_replay_queue #(.els_p(ELS), .data_width_p(DW)) dut (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .clr_v_i  (clr_v_i),
    .deq_v_i  (deq_v_i),
    .roll_v_i (roll_v_i),
    .data_i   (data_i),
    .v_i      (v_i),
    .ready_o  (ready_o),
    .data_o   (data_o),
    .v_o      (v_o),
    .yumi_i   (yumi_i),
    .empty_o  (empty_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_err = 0;

  // Scoreboard: uncommitted entries in order; 'issued' counts how many of them have been taken.
  logic [DW-1:0] model_q[$];
  int            issued = 0;

  typedef struct {
    logic          v;
    logic [DW-1:0] d;
    logic          yumi, deq, roll, clr;
    logic          ev;
    logic [DW-1:0] ed;
    logic          er, ee;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_step(input logic v, input logic [DW-1:0] d,
                            input logic y, input logic dq, input logic rl, input logic cl);
    logic acc;
    acc = v && (model_q.size() < ELS);
    if (cl) begin
      model_q.delete();
      issued = 0;
    end else if (rl) begin
      issued = 0;
    end else begin
      if (y) issued++;
      if (dq) begin
        void'(model_q.pop_front());
        issued--;
      end
    end
    if (acc) model_q.push_back(d);
  endtask

  // Called just after a negedge; returns just after the following negedge.
  task automatic cycle(input logic v, input logic [DW-1:0] d,
                       input logic y, input logic dq, input logic rl, input logic cl);
    v_i = v; data_i = d; yumi_i = y; deq_v_i = dq; roll_v_i = rl; clr_v_i = cl;
    @(posedge clk_i); #1;
    model_step(v, d, y, dq, rl, cl);
    v_i = 1'b0; yumi_i = 1'b0; deq_v_i = 1'b0; roll_v_i = 1'b0; clr_v_i = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic check_model(input string tag);
    logic ev;
    ev = (issued < model_q.size());
    chk({tag, ".v_o"}, DW'(v_o), DW'(ev));
    if (ev) chk({tag, ".data_o"}, data_o, model_q[issued]);
    chk({tag, ".ready_o"}, DW'(ready_o), DW'(model_q.size() < ELS));
    chk({tag, ".empty_o"}, DW'(empty_o), DW'(model_q.size() == 0));
  endtask

  task automatic drain(input string tag);
    while (issued < model_q.size()) begin
      cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
      check_model({tag, ".issue"});
    end
    while (model_q.size() > 0) begin
      cycle(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
      check_model({tag, ".commit"});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic v, y, dq;
    //             v     d       yumi  deq   roll  clr   ev    ed      er    ee
    tbl[0] = '{1'b1, 64'hA, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 64'hA, 1'b1, 1'b0};
    tbl[1] = '{1'b1, 64'hB, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 64'hB, 1'b1, 1'b0};
    tbl[2] = '{1'b1, 64'hC, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 64'hC, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 64'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0};
    tbl[4] = '{1'b0, 64'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0};
    tbl[5] = '{1'b0, 64'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0};
    tbl[6] = '{1'b0, 64'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0, 1'b1, 1'b1};

    repeat (2) @(negedge clk_i);
    reset_i = 1'b0;
    chk("reset.v_o", DW'(v_o), 64'd0);
    chk("reset.ready_o", DW'(ready_o), 64'd1);
    chk("reset.empty_o", DW'(empty_o), 64'd1);

    // Basic enqueue/issue/commit from the vector table
    for (int i = 0; i < 7; i++) begin
      cycle(tbl[i].v, tbl[i].d, tbl[i].yumi, tbl[i].deq, tbl[i].roll, tbl[i].clr);
      chk($sformatf("tbl%0d.v_o", i), DW'(v_o), DW'(tbl[i].ev));
      if (tbl[i].ev) chk($sformatf("tbl%0d.data_o", i), data_o, tbl[i].ed);
      chk($sformatf("tbl%0d.ready_o", i), DW'(ready_o), DW'(tbl[i].er));
      chk($sformatf("tbl%0d.empty_o", i), DW'(empty_o), DW'(tbl[i].ee));
    end

    // Fill to capacity, drop a 17th, then free one slot
    for (int i = 0; i < ELS; i++) begin
      cycle(1'b1, 64'h100 + DW'(i), 1'b0, 1'b0, 1'b0, 1'b0);
      check_model("fill");
    end
    chk("full.ready_o", DW'(ready_o), 64'd0);
    cycle(1'b1, 64'h999, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("drop.ready_o", DW'(ready_o), 64'd0);
    chk("drop.data_o", data_o, 64'h100);
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("issue1.ready_o", DW'(ready_o), 64'd0);
    cycle(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("deq1.ready_o", DW'(ready_o), 64'd1);
    while (issued < model_q.size()) begin
      cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
      check_model("full_drain");
    end
    chk("drop.v_o_after_15", DW'(v_o), 64'd0);
    drain("full_drain");

    // Random traffic across the wrap bit
    for (int i = 0; i < 40; i++) begin
      v  = 1'($urandom_range(0, 1));
      y  = 1'($urandom_range(0, 1)) && (issued < model_q.size());
      dq = 1'($urandom_range(0, 1)) && (issued > 0);
      cycle(v, {32'hBEEF0000, $urandom}, y, dq, 1'b0, 1'b0);
      check_model("wrap");
    end
    drain("wrap_drain");

    // Rollback: A..E, issue four, commit two, roll with a stray yumi
    for (int i = 0; i < 5; i++) cycle(1'b1, 64'hA0 + DW'(i), 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (4) cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (2) cycle(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("pre_roll.data_o", data_o, 64'hA4);
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("roll.v_o", DW'(v_o), 64'd1);
    chk("roll.data_o", data_o, 64'hA2);
    for (int i = 0; i < 3; i++) begin
      check_model("replay");
      cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    chk("replay_end.v_o", DW'(v_o), 64'd0);
    drain("roll_drain");

    // Clear with a same-cycle enqueue
    for (int i = 0; i < 4; i++) cycle(1'b1, 64'hC0 + DW'(i), 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 64'hEE, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("clr.v_o", DW'(v_o), 64'd1);
    chk("clr.data_o", data_o, 64'hEE);
    chk("clr.empty_o", DW'(empty_o), 64'd0);
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("clr.one_entry", DW'(v_o), 64'd0);
    cycle(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("clr.empty_after_commit", DW'(empty_o), 64'd1);

    // Steady-state lockstep at occupancy 3
    for (int i = 0; i < 3; i++) cycle(1'b1, 64'hD00 + DW'(i), 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 50; i++) begin
      cycle(1'b1, 64'hE00 + DW'(i), 1'b1, 1'b1, 1'b0, 1'b0);
      check_model("steady");
      chk("steady.ready_o", DW'(ready_o), 64'd1);
    end

    // Asynchronous reset between clock edges
    #2 reset_i = 1'b1;
    #1;
    chk("areset.v_o", DW'(v_o), 64'd0);
    chk("areset.ready_o", DW'(ready_o), 64'd1);
    chk("areset.empty_o", DW'(empty_o), 64'd1);
    model_q.delete();
    issued = 0;
    reset_i = 1'b0;
    @(negedge clk_i);
    cycle(1'b1, 64'hF00D, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("post_reset.v_o", DW'(v_o), 64'd1);
    chk("post_reset.data_o", data_o, 64'hF00D);
    check_model("post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
